// File: rtl/detector_pulsacion_pkg.sv
// ============================================================================
// detector_pulsacion_pkg : shared button constants and press-state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package detector_pulsacion_pkg;

   // Clock cycles per millisecond at 50 MHz; the debounce filter uses it too.
   localparam logic [31:0] C_CICLOS_MS = 32'd50000;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      PULSADO = 2'd1,
      LARGO   = 2'd2
   } estado_t;

   function automatic logic [31:0] ms_a_ciclos(input logic [31:0] ms,
                                               input logic [31:0] ciclos_ms);
      return ms * ciclos_ms;
   endfunction

endpackage

`default_nettype wire

// File: rtl/detector_pulsacion_hueco.sv
// ============================================================================
// contador_hueco : counts consecutive low samples, flags the sample that
// completes a gap of 'limite' cycles. Rev 1.0
// ============================================================================
`default_nettype none

module contador_hueco (
   input  logic        clk,
   input  logic        rst,
   input  logic        muestra,
   input  logic [31:0] limite,
   output logic        hueco_cumplido
);

   logic [31:0] r_h;

   // Saturates at the limit so a long idle period never re-flags the gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h <= '0;
      end else if (muestra) begin
         r_h <= '0;
      end else if (r_h < limite) begin
         r_h <= r_h + 32'd1;
      end
   end

   assign hueco_cumplido = !muestra && ((r_h + 32'd1) == limite);

endmodule

`default_nettype wire

// File: rtl/detector_pulsacion.sv
// ============================================================================
// detector_pulsacion : bridges filter re-trigger gaps and emits press, long
// press, auto-repeat and release events. Rev 1.0
// ============================================================================
`default_nettype none

module detector_pulsacion #(
   parameter logic [31:0] CICLOS_MS     = detector_pulsacion_pkg::C_CICLOS_MS,
   parameter logic [31:0] HUECO_CICLOS  = 32'd4,
   parameter logic [31:0] LARGO_MS      = 32'd1000,
   parameter logic [31:0] REPETICION_MS = 32'd200
) (
   input  logic clk,
   input  logic rst,
   input  logic pulso_ideal,
   output logic pulsado,
   output logic evento,
   output logic pulsacion_larga,
   output logic repeticion,
   output logic liberado
);

   import detector_pulsacion_pkg::*;

   localparam logic [31:0] c_largo      = ms_a_ciclos(LARGO_MS, CICLOS_MS);
   localparam logic [31:0] c_repeticion = ms_a_ciclos(REPETICION_MS, CICLOS_MS);

   estado_t     r_estado;
   logic        r_armado;
   logic [31:0] r_t;
   logic [31:0] r_r;
   logic        w_hueco;

   contador_hueco u_hueco (
      .clk            (clk),
      .rst            (rst),
      .muestra        (pulso_ideal),
      .limite         (HUECO_CICLOS),
      .hueco_cumplido (w_hueco)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado        <= REPOSO;
         r_armado        <= 1'b0;
         r_t             <= '0;
         r_r             <= '0;
         pulsado         <= 1'b0;
         evento          <= 1'b0;
         pulsacion_larga <= 1'b0;
         repeticion      <= 1'b0;
         liberado        <= 1'b0;
      end else begin
         evento          <= 1'b0;
         pulsacion_larga <= 1'b0;
         repeticion      <= 1'b0;
         liberado        <= 1'b0;

         // A button already held out of reset must go low once before it counts.
         if (!pulso_ideal) begin
            r_armado <= 1'b1;
         end

         case (r_estado)
            REPOSO: begin
               pulsado <= 1'b0;
               if (r_armado && pulso_ideal) begin
                  r_estado <= PULSADO;
                  evento   <= 1'b1;
                  pulsado  <= 1'b1;
                  r_t      <= '0;
               end
            end
            PULSADO: begin
               r_t <= r_t + 32'd1;
               if (w_hueco) begin
                  r_estado <= REPOSO;
                  liberado <= 1'b1;
                  pulsado  <= 1'b0;
               end else if ((r_t + 32'd1) == c_largo) begin
                  r_estado        <= LARGO;
                  pulsacion_larga <= 1'b1;
                  r_r             <= '0;
               end
            end
            LARGO: begin
               // Release has priority over a repeat falling on the same edge.
               if (w_hueco) begin
                  r_estado <= REPOSO;
                  liberado <= 1'b1;
                  pulsado  <= 1'b0;
               end else if ((r_r + 32'd1) == c_repeticion) begin
                  repeticion <= 1'b1;
                  r_r        <= '0;
               end else begin
                  r_r <= r_r + 32'd1;
               end
            end
            default: begin
               r_estado <= REPOSO;
               pulsado  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
